// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD and the FCS, streams the payload, reports per-frame status.
// Optional CRC residue check is built when RX_CRC_CHECK_EN is defined.
module gmii_rx_frame #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0a_35_01_fe_c0,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_done,
  output logic [3:0]  rx_err,
  output logic        frame_good,
  output logic [15:0] frame_len
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_DROP,
    S_DATA,
    S_GIANT
  } state_t;

  localparam logic [15:0] GIANT_N   = 16'(MAX_LEN + 1);
  localparam logic [15:0] GIANT_LEN = 16'(MAX_LEN - 4);

  state_t          state, state_nxt;
  logic [15:0]     n_cnt, n_inc;
  logic [3:0][7:0] dly;
  logic            er_seen, uc_ok, bc_ok;
  logic            crc_bad;
  logic [47:0]     mac_shift;
  logic [3:0]      data_err, giant_err;

  assign n_inc     = (n_cnt == 16'hFFFF) ? n_cnt : n_cnt + 16'd1;
  // Destination-address byte expected at index n_cnt (byte 0 is the MSB).
  assign mac_shift = LOCAL_MAC >> {3'd5 - n_cnt[2:0], 3'b000};
  assign data_err  = {~(uc_ok | bc_ok), er_seen, (n_cnt < 16'd64), crc_bad};
  assign giant_err = {~(uc_ok | bc_ok), er_seen, 1'b1, crc_bad};

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign crc_bad = (crc != 32'hDEBB20E3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 32'hFFFFFFFF;
    end else if (state == S_PREAMBLE && gmii_rx_dv && gmii_rxd == 8'hD5) begin
      crc <= 32'hFFFFFFFF;
    end else if (state == S_DATA && gmii_rx_dv) begin
      crc <= crc_next(crc, gmii_rxd);
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_IDLE: if (!gmii_rx_dv) state_nxt = S_IDLE;
      S_IDLE:      if (gmii_rx_dv) state_nxt = (gmii_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE: begin
        if (!gmii_rx_dv)             state_nxt = S_IDLE;
        else if (gmii_rxd == 8'hD5)  state_nxt = S_DATA;
        else if (gmii_rxd != 8'h55)  state_nxt = S_DROP;
      end
      S_DROP:      if (!gmii_rx_dv) state_nxt = S_IDLE;
      S_DATA: begin
        if (!gmii_rx_dv)             state_nxt = S_IDLE;
        else if (n_inc == GIANT_N)   state_nxt = S_GIANT;
      end
      S_GIANT:     if (!gmii_rx_dv) state_nxt = S_IDLE;
      default:     state_nxt = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cnt      <= '0;
      dly        <= '0;
      er_seen    <= 1'b0;
      uc_ok      <= 1'b0;
      bc_ok      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_done    <= 1'b0;
      rx_err     <= '0;
      frame_good <= 1'b0;
      frame_len  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_done  <= 1'b0;
      case (state)
        S_PREAMBLE: begin
          if (gmii_rx_dv && gmii_rxd == 8'hD5) begin
            n_cnt   <= '0;
            er_seen <= 1'b0;
            uc_ok   <= 1'b1;
            bc_ok   <= 1'b1;
          end
        end
        S_DATA: begin
          if (gmii_rx_dv) begin
            dly   <= {dly[2:0], gmii_rxd};
            n_cnt <= n_inc;
            if (gmii_rx_er) er_seen <= 1'b1;
            if (n_cnt < 16'd6) begin
              if (gmii_rxd != mac_shift[7:0]) uc_ok <= 1'b0;
              if (gmii_rxd != 8'hFF)          bc_ok <= 1'b0;
            end
            // The oldest delay-line byte leaves once four newer bytes are behind it.
            if (n_inc != GIANT_N && n_inc >= 16'd5) begin
              rx_data  <= dly[3];
              rx_valid <= 1'b1;
              rx_sof   <= (n_inc == 16'd5);
            end
          end else begin
            rx_done    <= 1'b1;
            rx_err     <= data_err;
            frame_good <= (data_err == 4'd0);
            frame_len  <= (n_cnt >= 16'd4) ? n_cnt - 16'd4 : 16'd0;
          end
        end
        S_GIANT: begin
          if (gmii_rx_dv) begin
            if (gmii_rx_er) er_seen <= 1'b1;
          end else begin
            rx_done    <= 1'b1;
            rx_err     <= giant_err;
            frame_good <= 1'b0;
            frame_len  <= GIANT_LEN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Self-checking bench for gmii_rx_frame: randomized frames against a frame-level reference model.
module tb_gmii_rx_frame;
  localparam logic [47:0] LOCAL = 48'h00_0a_35_01_fe_c0;
  localparam int          MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_done, frame_good;
  logic [3:0]  rx_err;
  logic [15:0] frame_len;
  logic [31:0] outs;

  gmii_rx_frame #(.LOCAL_MAC(LOCAL), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_rxd(gmii_rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .rx_done(rx_done), .rx_err(rx_err), .frame_good(frame_good), .frame_len(frame_len)
  );

  assign outs = {rx_data, rx_valid, rx_sof, rx_done, rx_err, frame_good, frame_len};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int bad_sof = 0;
  int rst_snap = 0;

  logic [7:0] frame_q[$];
  logic [7:0] exp_bytes_q[$];
  logic [3:0] exp_err_q[$];
  int         exp_len_q[$];
  bit         exp_giant_q[$];
  int         sfd_q[$];

  logic [7:0] got_bytes_q[$];
  logic [3:0] got_err_q[$];
  int         got_len_q[$];
  bit         got_good_q[$];
  int         sof_cyc_q[$];
  int         done_lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_bytes_q.push_back(rx_data);
      last_valid_cyc = cyc;
    end
    if (rx_sof) begin
      sof_cyc_q.push_back(cyc);
      if (!rx_valid) bad_sof++;
    end
    if (rx_done) begin
      got_err_q.push_back(rx_err);
      got_len_q.push_back(int'(frame_len));
      got_good_q.push_back(frame_good);
      done_lat_q.push_back(cyc - last_valid_cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Ethernet FCS over frame_q[0..n-1] (with final inversion).
  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frame_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] da, input int len);
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < len - 10; i++) frame_q.push_back(8'($urandom));
    fcs = crc_ref(len - 4);
    for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
  endtask

  task automatic expect_frame(input bit er);
    int          L, len;
    bit          giant;
    logic [3:0]  e;
    logic [47:0] da;
    L     = frame_q.size();
    giant = (L > MAX_LEN);
    len   = giant ? MAX_LEN - 4 : ((L >= 4) ? L - 4 : 0);
    da    = '0;
    for (int i = 0; i < 6; i++) da = {da[39:0], frame_q[i]};
    e    = 4'd0;
    e[1] = giant || (L < 64);
    e[2] = er;
    e[3] = (da != LOCAL) && (da != 48'hFFFF_FFFF_FFFF);
`ifdef RX_CRC_CHECK_EN
    e[0] = crc_ref(L - 4) != {frame_q[L-1], frame_q[L-2], frame_q[L-3], frame_q[L-4]};
`endif
    exp_err_q.push_back(e);
    exp_len_q.push_back(len);
    exp_giant_q.push_back(giant);
    for (int i = 0; i < len; i++) exp_bytes_q.push_back(frame_q[i]);
  endtask

  task automatic send(input int er_idx, input int rst_idx, input int ipg);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rx_er = 1'b0;
      gmii_rxd   = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      if (i == 0 && rst_idx < 0) sfd_q.push_back(cyc);
      if (i == rst_idx) begin
        rst_n = 1'b0;
        #1;
        chk("reset_clears_outputs", int'(outs), 0);
        rst_snap = got_bytes_q.size();
      end else if (rst_idx >= 0 && i == rst_idx + 1) begin
        rst_n = 1'b1;
      end
      gmii_rxd   = frame_q[i];
      gmii_rx_er = (i == er_idx);
    end
    for (int k = 0; k < ipg; k++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'h00;
    end
  endtask

  task automatic clear_all();
    exp_bytes_q.delete(); exp_err_q.delete(); exp_len_q.delete(); exp_giant_q.delete();
    sfd_q.delete(); got_bytes_q.delete(); got_err_q.delete(); got_len_q.delete();
    got_good_q.delete(); sof_cyc_q.delete(); done_lat_q.delete();
  endtask

  task automatic check_batch(input string name);
    int w, n, mism;
    w = 0;
    while (got_err_q.size() < exp_err_q.size() && w < 200) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    chk({name, "_done_count"}, got_err_q.size(), exp_err_q.size());
    chk({name, "_sof_count"}, sof_cyc_q.size(), sfd_q.size());
    chk({name, "_byte_count"}, got_bytes_q.size(), exp_bytes_q.size());
    mism = 0;
    n = (got_bytes_q.size() < exp_bytes_q.size()) ? got_bytes_q.size() : exp_bytes_q.size();
    for (int i = 0; i < n; i++) if (got_bytes_q[i] !== exp_bytes_q[i]) mism++;
    chk({name, "_byte_mismatches"}, mism, 0);
    n = (got_err_q.size() < exp_err_q.size()) ? got_err_q.size() : exp_err_q.size();
    for (int i = 0; i < n; i++) begin
      if (exp_giant_q[i]) begin
        chk({name, "_giant_err1"}, int'(got_err_q[i][1]), 1);
      end else begin
        chk({name, "_rx_err"}, int'(got_err_q[i]), int'(exp_err_q[i]));
        chk({name, "_frame_good"}, int'(got_good_q[i]), int'(exp_err_q[i] == 4'd0));
        chk({name, "_done_latency"}, done_lat_q[i], 1);
      end
      chk({name, "_frame_len"}, got_len_q[i], exp_len_q[i]);
    end
    n = (sof_cyc_q.size() < sfd_q.size()) ? sof_cyc_q.size() : sfd_q.size();
    for (int i = 0; i < n; i++) chk({name, "_sof_latency"}, sof_cyc_q[i] - sfd_q[i], 5);
    clear_all();
  endtask

  function automatic logic [47:0] pick_da(input int sel);
    if (sel == 0) return LOCAL;
    if (sel == 1) return 48'hFFFF_FFFF_FFFF;
    return {16'h1234, 32'($urandom)};
  endfunction

  initial begin
    int d0, len;
    rst_n = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(outs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    build_frame(LOCAL, 64);
    expect_frame(1'b0);
    send(-1, -1, 12);
    check_batch("good64");

    build_frame(LOCAL, 64);
    frame_q[20] = frame_q[20] ^ 8'h01;
    expect_frame(1'b0);
    send(-1, -1, 12);
    check_batch("corrupt");

    build_frame(48'hFFFF_FFFF_FFFF, 64);
    expect_frame(1'b0);
    send(-1, -1, 12);
    check_batch("bcast");

    build_frame(48'h1122_3344_5566, 64);
    expect_frame(1'b0);
    send(-1, -1, 12);
    check_batch("foreign_da");

    build_frame(LOCAL, 40);
    expect_frame(1'b0);
    send(-1, -1, 12);
    check_batch("runt40");

    build_frame(LOCAL, 80);
    expect_frame(1'b1);
    send(10, -1, 12);
    check_batch("gmii_er");

    build_frame(LOCAL, 1600);
    expect_frame(1'b0);
    send(-1, -1, 12);
    check_batch("giant");

    // Back-to-back frames separated by a single idle cycle.
    for (int f = 0; f < 3; f++) begin
      build_frame(pick_da(f), 64 + int'($urandom_range(0, 200)));
      expect_frame(1'b0);
      send(-1, -1, 1);
    end
    check_batch("b2b");

    // Reset mid-frame, released while dv is still high.
    d0 = got_err_q.size();
    build_frame(LOCAL, 100);
    send(-1, 30, 6);
    repeat (4) @(posedge clk);
    chk("no_done_after_reset", got_err_q.size(), d0);
    chk("no_emit_after_reset", got_bytes_q.size(), rst_snap);
    clear_all();

    build_frame(LOCAL, 64);
    expect_frame(1'b0);
    send(-1, -1, 12);
    check_batch("after_reset");

    // Randomized mix: lengths, DA kinds, corruption, rx_er and gap lengths.
    for (int f = 0; f < 8; f++) begin
      int er_i;
      len = int'($urandom_range(12, 220));
      build_frame(pick_da(int'($urandom_range(0, 2))), len);
      if ($urandom_range(0, 3) == 0) frame_q[$urandom_range(0, len - 1)] ^= 8'h80;
      er_i = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      expect_frame(er_i >= 0);
      send(er_i, -1, int'($urandom_range(1, 4)));
    end
    check_batch("random");

    chk("sof_without_valid", bad_sof, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
